brpuf_eval_ctrl: RTL
====================

# brpuf_eval_ctrl

Sequencer for the 32-stage bistable-ring PUF. Accepts a 32-bit challenge, drives the ring's challenge and reset inputs through a reset/settle/sample sequence, and repeats the evaluation EVALS times. It majority-votes the synchronized ring response and returns one stable response bit. It sits between the host/register interface and the ring instance, which it owns exclusively.

## Interface
- RESET_CYCLES, 4: cycles `ring_reset` is held high per evaluation; must be ≥1.
- SETTLE_CYCLES, 64: cycles the ring runs free before sampling; must be ≥3 to cover the synchronizer.
- EVALS, 5: evaluations per request; must be odd and ≥1.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- challenge_in  in  32  challenge, sampled on the accepted `start`.
- busy  out  1  high from the cycle after acceptance through the last SAMPLE cycle.
- done  out  1  one-cycle pulse; `resp_out` is valid from that cycle.
- resp_out  out  1  majority-voted response; held until the next `done`.
- unstable  out  1  evaluations disagreed; updated with `done` (see Configuration).
- ring_challenge  out  32  to ring `challenge`.
- ring_reset  out  1  to ring `reset`.
- ring_response  in  1  from ring `response`; asynchronous to `clk`.

## Operation
- States: IDLE, RESET, SETTLE, SAMPLE, DONE.
- IDLE:
  - `ring_reset`=1 (ring parked).
  - On `start`: `ring_challenge`←`challenge_in`, eval_cnt←0, ones_cnt←0, go to RESET.
- RESET: `ring_reset`=1 for RESET_CYCLES cycles, then SETTLE.
- SETTLE: `ring_reset`=0 for SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: one cycle.
  - `ring_reset`=0.
  - ones_cnt += synchronized response; eval_cnt += 1.
  - If eval_cnt (before increment) = EVALS-1, go to DONE; else go to RESET.
- DONE: one cycle.
  - `done`=1, `ring_reset`=1.
  - `resp_out` ← (ones_cnt > EVALS/2), using the final value including the last sample.
  - Then go to IDLE.
- `ring_challenge` changes only in IDLE on acceptance, never while `ring_reset`=0.
- `ring_response` passes through a 2-flop synchronizer before use.
- Counter widths:
  - Phase counter: $clog2(max(RESET_CYCLES, SETTLE_CYCLES)).
  - ones_cnt and eval_cnt: $clog2(EVALS+1).
  - No wrap is possible within one request.
- `start` outside IDLE, including in the DONE cycle, is ignored; it is not queued.
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `resp_out`=0, `unstable`=0.
  - `ring_challenge`=0, `ring_reset`=1.
  - Synchronizer flops 0, all counters 0.
- Reset mid-request aborts within one cycle: no `done`, `resp_out` cleared, ring parked.

## Timing
- Per evaluation: RESET_CYCLES + SETTLE_CYCLES + 1 cycles.
- `start` accepted at cycle 0 → `done` at cycle EVALS·(RESET_CYCLES+SETTLE_CYCLES+1)+1. With defaults this is cycle 346.
- `busy` is high from cycle 1 through cycle EVALS·(R+S+1); it is low in DONE and IDLE.
- Back-to-back requests: the earliest next acceptance is the cycle after `done`.
- Synchronizer latency is 2 cycles; the sample in SAMPLE reflects the ring state ≥2 cycles earlier, which lies inside SETTLE.
- All outputs are registered.

## Configuration
- `BRPUF_STABILITY_EN` defined:
  - The block tracks whether every sample in the request equals the first sample.
  - On `done`, `unstable`=1 if any sample differed; otherwise 0.
- Not defined: `unstable` is tied to 0 and the comparison logic is not built.
- `resp_out` is identical in both builds.

## Structure
- Package `brpuf_pkg`:
  - State enum.
  - Default parameter constants (RESET_CYCLES, SETTLE_CYCLES, EVALS).
  - Challenge width constant (32).
- Sub-module `brpuf_sync2`: 2-flop synchronizer with synchronous active-high reset to 0. The ring instance itself is outside this block.

## Test plan
- Behavioural ring model returns a constant 1; start with `challenge_in`=32'hA5A5_5A5A → `ring_challenge`=32'hA5A5_5A5A while `ring_reset`=1; `done` at cycle 346; `resp_out`=1; `unstable`=0.
- Model returns samples 1,0,1,0,1 → `resp_out`=1. Samples 0,0,1,1,0 → `resp_out`=0. With `BRPUF_STABILITY_EN`, `unstable`=1 in both cases.
- `start` pulsed at cycles 10 and 346 of an active request → both ignored; exactly one `done`; `ring_challenge` never changes while `ring_reset`=0.
- `reset` asserted at cycle 100 of a request → next cycle: IDLE, `ring_reset`=1, `busy`=0, `resp_out`=0; no `done` follows.
- RESET_CYCLES=1, SETTLE_CYCLES=3, EVALS=1 → `done` exactly at cycle 6; a new request accepted at cycle 7 completes at cycle 13.
- Response toggling asynchronously during RESET only → sampled value equals the settled level; each SETTLE phase shows exactly SETTLE_CYCLES cycles of `ring_reset`=0.

Source files
------------

// File: rtl/brpuf_pkg.sv
// Shared types and default constants for the bistable-ring PUF evaluation controller.
package brpuf_pkg;

    localparam int CHAL_W            = 32;
    localparam int DEF_RESET_CYCLES  = 4;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_EVALS         = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/brpuf_sync2.sv
// Two-flop synchronizer bringing the asynchronous ring response into the clk domain.
module brpuf_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/brpuf_eval_ctrl.sv
// Bistable-ring PUF sequencer: reset/settle/sample the ring EVALS times and
// majority-vote the synchronized response into one bit.
// Optional build macro BRPUF_STABILITY_EN adds the sample-disagreement flag.
module brpuf_eval_ctrl
    import brpuf_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int EVALS         = DEF_EVALS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge_in,
    output logic              busy,
    output logic              done,
    output logic              resp_out,
    output logic              unstable,
    output logic [CHAL_W-1:0] ring_challenge,
    output logic              ring_reset,
    input  logic              ring_response
);

    localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int CNT_W  = $clog2(EVALS + 1);

    localparam logic [PH_W-1:0]  R_LAST = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0]  S_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LAST = CNT_W'(EVALS - 1);
    localparam logic [CNT_W-1:0] HALF   = CNT_W'(EVALS / 2);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q;
    logic [CNT_W-1:0]  eval_q;
    logic [CNT_W-1:0]  ones_q;
    logic [CNT_W-1:0]  ones_next;
    logic              resp_sync;
    logic              accept;
    logic              last_sample;

    brpuf_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ring_response),
        .q     (resp_sync)
    );

    // Next-state decode and per-cycle qualifiers.
    always_comb begin
        state_d     = state_q;
        accept      = (state_q == ST_IDLE) && start;
        last_sample = (state_q == ST_SAMPLE) && (eval_q == E_LAST);
        ones_next   = ones_q + CNT_W'(resp_sync);
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RESET;
            ST_RESET:  if (phase_q == R_LAST) state_d = ST_SETTLE;
            ST_SETTLE: if (phase_q == S_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (eval_q == E_LAST) ? ST_DONE : ST_RESET;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Phase counter restarts on every state change; evaluation and ones counters
    // clear on acceptance and advance once per SAMPLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            eval_q  <= '0;
            ones_q  <= '0;
        end else begin
            if (state_d != state_q)
                phase_q <= '0;
            else if (state_q == ST_RESET || state_q == ST_SETTLE)
                phase_q <= phase_q + PH_W'(1);
            if (accept) begin
                eval_q <= '0;
                ones_q <= '0;
            end else if (state_q == ST_SAMPLE) begin
                eval_q <= eval_q + CNT_W'(1);
                ones_q <= ones_next;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    // The vote folds in the final sample directly so resp_out is ready in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            resp_out       <= 1'b0;
            ring_challenge <= '0;
            ring_reset     <= 1'b1;
        end else begin
            busy       <= (state_d == ST_RESET) || (state_d == ST_SETTLE) ||
                          (state_d == ST_SAMPLE);
            done       <= (state_d == ST_DONE);
            ring_reset <= (state_d == ST_IDLE) || (state_d == ST_RESET) ||
                          (state_d == ST_DONE);
            if (accept)
                ring_challenge <= challenge_in;
            if (last_sample)
                resp_out <= (ones_next > HALF);
        end
    end

`ifdef BRPUF_STABILITY_EN
    logic first_q;
    logic diff_q;

    // Remember the first sample and flag any later sample that disagrees with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_q  <= 1'b0;
            diff_q   <= 1'b0;
            unstable <= 1'b0;
        end else begin
            if (accept)
                diff_q <= 1'b0;
            if (state_q == ST_SAMPLE) begin
                if (eval_q == '0)
                    first_q <= resp_sync;
                else if (resp_sync != first_q)
                    diff_q <= 1'b1;
            end
            if (last_sample)
                unstable <= diff_q | ((eval_q != '0) && (resp_sync != first_q));
        end
    end
`else
    assign unstable = 1'b0;
`endif

endmodule
